// File: rtl/debug_resp_tx_pkg.sv
// Shared types and helpers for the debug response framer.
// Frame length grows by one checksum byte when DEBUG_RESP_CSUM_EN is defined.
package debug_resp_tx_pkg;

    localparam logic [7:0] CMD_START = 8'h01;
    localparam logic [7:0] CMD_PM_WR = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    function automatic int frame_len(input int addr_w, input int data_w);
        int n;
        n = 32'sd1 + addr_w / 32'sd8 + data_w / 32'sd8;
`ifdef DEBUG_RESP_CSUM_EN
        n = n + 32'sd1;
`endif
        return n;
    endfunction

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/debug_resp_tx_if.sv
// Request and UART-TX handshake bundle for the debug response framer.
interface debug_resp_tx_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_code;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic              frame_done;

    modport master (
        output req_valid, req_code, req_addr, req_data, tx_done,
        input  req_ready, tx_start, tx_data, frame_done
    );

    modport slave (
        input  req_valid, req_code, req_addr, req_data, tx_done,
        output req_ready, tx_start, tx_data, frame_done
    );
endinterface

// File: rtl/debug_resp_tx.sv
// Debug response framer: code, address (LSB first), data (LSB first) as a UART byte stream.
// Optional trailing XOR checksum byte when DEBUG_RESP_CSUM_EN is defined.
module debug_resp_tx
    import debug_resp_tx_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    debug_resp_tx_if.slave  bus
);

    localparam int N     = frame_len(ADDR_W, DATA_W);
    localparam int IDX_W = $clog2(N + 32'sd1);
    localparam int PAY_W = ADDR_W + DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 32'sd1);

    state_t            state_r;
    logic              req_ready_r;
    logic              tx_start_r;
    logic              frame_done_r;
    logic [7:0]        tx_data_r;
    logic [PAY_W-1:0]  pay_r;
    logic [IDX_W-1:0]  idx_r;
`ifdef DEBUG_RESP_CSUM_EN
    localparam logic [IDX_W-1:0] CSUM_PREV_IDX = IDX_W'(N - 32'sd2);
    logic [7:0]        csum_r;
`endif

    // Framer FSM: payload shift register, byte index and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b1;
            tx_start_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            frame_done_r <= 1'b0;
            pay_r        <= '0;
            idx_r        <= '0;
`ifdef DEBUG_RESP_CSUM_EN
            csum_r       <= 8'h00;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    frame_done_r <= 1'b0;
                    if (bus.req_valid && req_ready_r) begin
                        // Code goes out directly; only addr/data wait in the shift register.
                        pay_r       <= {bus.req_data, bus.req_addr};
                        tx_data_r   <= bus.req_code;
                        idx_r       <= '0;
                        tx_start_r  <= 1'b1;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_SEND;
`ifdef DEBUG_RESP_CSUM_EN
                        csum_r      <= 8'h00;
`endif
                    end else begin
                        tx_start_r  <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                ST_SEND: begin
                    tx_start_r   <= 1'b0;
                    frame_done_r <= 1'b0;
                    state_r      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.tx_done) begin
                        if (idx_r == LAST_IDX) begin
                            frame_done_r <= 1'b1;
                            req_ready_r  <= 1'b1;
                            state_r      <= ST_IDLE;
                        end else begin
                            idx_r      <= idx_r + IDX_W'(1);
                            pay_r      <= {8'h00, pay_r[PAY_W-1:8]};
                            tx_start_r <= 1'b1;
                            state_r    <= ST_SEND;
`ifdef DEBUG_RESP_CSUM_EN
                            csum_r     <= csum_step(csum_r, tx_data_r);
                            if (idx_r == CSUM_PREV_IDX) begin
                                tx_data_r <= csum_step(csum_r, tx_data_r);
                            end else begin
                                tx_data_r <= pay_r[7:0];
                            end
`else
                            tx_data_r  <= pay_r[7:0];
`endif
                        end
                    end else begin
                        tx_start_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    tx_start_r   <= 1'b0;
                    frame_done_r <= 1'b0;
                    idx_r        <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.tx_start   = tx_start_r;
    assign bus.tx_data    = tx_data_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_debug_resp_tx.sv
// Self-checking bench for debug_resp_tx: directed scenarios plus randomized frames vs a byte-list model.
`timescale 1ns/1ps
module tb_debug_resp_tx;

`ifdef DEBUG_RESP_CSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_starts = 0;
    int   exp_starts = 0;

    debug_resp_tx_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    debug_resp_tx #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) n_starts = n_starts + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: the frame as a list of bytes, built from the framing rules.
    function automatic logic [7:0] ref_byte(input logic [7:0] code, input logic [15:0] addr,
                                            input logic [15:0] data, input int i);
        logic [7:0] b [NB];
        b[0] = code;
        for (int k = 0; k < 2; k++) begin
            b[1 + k] = 8'((addr >> (8 * k)) & 16'h00FF);
            b[3 + k] = 8'((data >> (8 * k)) & 16'h00FF);
        end
`ifdef DEBUG_RESP_CSUM_EN
        b[5] = 8'h00;
        for (int k = 0; k < 5; k++) b[5] = b[5] ^ b[k];
`endif
        return b[i];
    endfunction

    task automatic issue(input logic [7:0] code, input logic [15:0] addr, input logic [15:0] data);
        int k;
        bus.req_code  = code;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_valid = 1'b1;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("accept_within_bound", 32'(k < 50), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Plays the UART side for one frame; entered at the cycle where byte 0's tx_start is expected.
    task automatic serve(input logic [7:0] code, input logic [15:0] addr, input logic [15:0] data,
                         input int lat_lo, input int lat_hi, input bit spur, input int abort_at,
                         input bit has_next, input logic [7:0] ncode, input logic [15:0] naddr,
                         input logic [15:0] ndata);
        logic [7:0] eb;
        int lat;
        for (int i = 0; i < NB; i++) begin
            eb = ref_byte(code, addr, data, i);
            check_eq($sformatf("tx_start_b%0d", i), 32'(bus.tx_start), 32'd1);
            check_eq($sformatf("tx_data_b%0d", i), 32'(bus.tx_data), 32'(eb));
            if (i == 0) check_eq("req_ready_busy", 32'(bus.req_ready), 32'd0);
            if (has_next && i == 2) begin
                bus.req_code  = ncode;
                bus.req_addr  = naddr;
                bus.req_data  = ndata;
                bus.req_valid = 1'b1;
            end
            lat = $urandom_range(lat_hi, lat_lo);
            if (spur && i == 0) bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
            check_eq("tx_start_pulse_width", 32'(bus.tx_start), 32'd0);
            if (abort_at == i) begin
                repeat (2) @(negedge clk);
                reset_n = 1'b0;
                repeat (2) @(negedge clk);
                check_eq("rst_tx_start", 32'(bus.tx_start), 32'd0);
                check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
                check_eq("rst_frame_done", 32'(bus.frame_done), 32'd0);
                reset_n = 1'b1;
                @(negedge clk);
                check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
                exp_starts += i + 1;
                repeat (3) begin
                    bus.tx_done = 1'b1;
                    @(negedge clk);
                    bus.tx_done = 1'b0;
                    @(negedge clk);
                    check_eq("post_rst_frame_done", 32'(bus.frame_done), 32'd0);
                end
                check_eq("post_rst_start_count", n_starts, exp_starts);
                return;
            end
            repeat (lat - 1) @(negedge clk);
            check_eq($sformatf("tx_data_hold_b%0d", i), 32'(bus.tx_data), 32'(eb));
            if (i >= 2) check_eq("req_ready_while_busy", 32'(bus.req_ready), 32'd0);
            check_eq("frame_done_early", 32'(bus.frame_done), 32'd0);
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
        end
        check_eq("frame_done_pulse", 32'(bus.frame_done), 32'd1);
        check_eq("req_ready_at_done", 32'(bus.req_ready), 32'd1);
        exp_starts += NB;
        check_eq("start_count", n_starts, exp_starts);
        @(negedge clk);
        if (has_next) bus.req_valid = 1'b0;
        check_eq("frame_done_one_cycle", 32'(bus.frame_done), 32'd0);
    endtask

    logic [7:0]  c, nc;
    logic [15:0] a, na, d, nd;
    bit          hn;
    logic [7:0]  codes [3];

    initial begin
        codes[0] = 8'h01;
        codes[1] = 8'h02;
        codes[2] = 8'h04;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_code  = 8'h00;
        bus.req_addr  = 16'h0000;
        bus.req_data  = 16'h0000;
        bus.tx_done   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("reset_tx_start", 32'(bus.tx_start), 32'd0);
        check_eq("reset_tx_data", 32'(bus.tx_data), 32'd0);
        check_eq("reset_frame_done", 32'(bus.frame_done), 32'd0);

        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        @(negedge clk);
        check_eq("idle_spur_tx_start", 32'(bus.tx_start), 32'd0);
        check_eq("idle_spur_req_ready", 32'(bus.req_ready), 32'd1);

        // READ frame, then a busy-time request that chains back-to-back into a third frame.
        issue(8'h04, 16'h0001, 16'h180F);
        serve(8'h04, 16'h0001, 16'h180F, 10, 10, 1'b0, -1, 1'b1, 8'h02, 16'h1234, 16'hBEEF);
        serve(8'h02, 16'h1234, 16'hBEEF, 1, 6, 1'b1, -1, 1'b1, 8'h01, 16'hA55A, 16'h0FF0);
        serve(8'h01, 16'hA55A, 16'h0FF0, 1, 3, 1'b0, -1, 1'b0, 8'h00, 16'h0000, 16'h0000);

        issue(8'h04, 16'hABCD, 16'h5678);
        serve(8'h04, 16'hABCD, 16'h5678, 2, 5, 1'b0, 3, 1'b0, 8'h00, 16'h0000, 16'h0000);
        issue(8'h04, 16'h0001, 16'h180F);
        serve(8'h04, 16'h0001, 16'h180F, 1, 4, 1'b0, -1, 1'b0, 8'h00, 16'h0000, 16'h0000);

        c = codes[$urandom_range(2, 0)];
        a = 16'($urandom);
        d = 16'($urandom);
        issue(c, a, d);
        for (int r = 0; r < 12; r++) begin
            hn = (r < 11) ? 1'($urandom_range(1, 0)) : 1'b0;
            nc = codes[$urandom_range(2, 0)];
            na = 16'($urandom);
            nd = 16'($urandom);
            serve(c, a, d, 1, 8, 1'($urandom_range(1, 0)), -1, hn, nc, na, nd);
            c = nc;
            a = na;
            d = nd;
            if (!hn && r < 11) issue(c, a, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
